aes_key_expander: RTL and testbench

//  Round-key source for aes_en_core. Latches the 128-bit cipher key, expands it (FIPS-197, AES-128)

---
 rtl/aes_key_expander.sv | 110 +++++++++++
 tb/tb_aes_key_expander.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128 key schedule into an 11-entry key store, served by round index
module aes_key_expander #(
  parameter int NO_ROWS   = 4,
  parameter int NO_COLS   = 4,
  parameter int NO_ROUNDS = 10
) (
  input  logic                                 aes_clk,
  input  logic                                 resetn,
  input  logic                                 key_exp_en,
  input  logic                                 key_load_i,
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] cipher_key_i,
  input  logic                                 key_req_i,
  input  logic [3:0]                           key_sel_i,
  output logic                                 key_vld_o,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] round_key_o,
  output logic                                 key_exp_busy_o,
  output logic                                 key_exp_done_o,
  output logic                                 key_sel_err_o
);
  typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] key_t;
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rcon indexed directly by the round counter; unused slots are zero
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // One AES-128 schedule step: t = SubWord(RotWord(w3)) ^ Rcon, then chained column XORs
  function automatic key_t next_key(key_t k, logic [7:0] rc);
    logic [NO_ROWS-1:0][7:0] t;
    key_t n;
    for (int r = 0; r < NO_ROWS; r++) t[r] = SBOX[k[(r + 1) % NO_ROWS][NO_COLS-1]];
    t[0] = t[0] ^ rc;
    for (int r = 0; r < NO_ROWS; r++) begin
      n[r][0] = k[r][0] ^ t[r];
      for (int c = 1; c < NO_COLS; c++) n[r][c] = k[r][c] ^ n[r][c-1];
    end
    return n;
  endfunction

  state_t                   state;
  logic [3:0]               cnt;
  logic [NO_ROUNDS:0][NO_ROWS-1:0][NO_COLS-1:0][7:0] store;
  key_t                     nxt;
  logic                     sel_ok;

  // Next round key derived from the previously written store entry
  always_comb begin
    nxt    = next_key(store[cnt - 4'd1], RCON[cnt]);
    sel_ok = key_sel_i <= 4'(NO_ROUNDS);
  end

  // Control FSM, key store and registered handshake outputs
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      cnt            <= '0;
      store          <= '0;
      round_key_o    <= '0;
      key_vld_o      <= 1'b0;
      key_exp_busy_o <= 1'b0;
      key_exp_done_o <= 1'b0;
      key_sel_err_o  <= 1'b0;
    end else begin
      key_vld_o     <= 1'b0;
      key_sel_err_o <= 1'b0;
      if (!key_exp_en) begin
        state          <= IDLE;
        key_exp_busy_o <= 1'b0;
        key_exp_done_o <= 1'b0;
      end else if (key_load_i) begin
        store[0]       <= cipher_key_i;
        cnt            <= 4'd1;
        state          <= EXPAND;
        key_exp_busy_o <= 1'b1;
        key_exp_done_o <= 1'b0;
      end else begin
        case (state)
          EXPAND: begin
            store[cnt] <= nxt;
            cnt        <= cnt + 4'd1;
            if (cnt == 4'(NO_ROUNDS)) begin
              state          <= READY;
              key_exp_busy_o <= 1'b0;
              key_exp_done_o <= 1'b1;
            end
          end
          READY: begin
            key_vld_o     <= key_req_i & sel_ok;
            key_sel_err_o <= key_req_i & ~sel_ok;
            if (key_req_i && sel_ok) round_key_o <= store[key_sel_i];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed FIPS-197 vectors against the AES-128 key expander
module tb_aes_key_expander;
  logic                  aes_clk = 1'b0;
  logic                  resetn = 1'b0;
  logic                  key_exp_en = 1'b0;
  logic                  key_load_i = 1'b0;
  logic                  key_req_i = 1'b0;
  logic [3:0]            key_sel_i = '0;
  logic [3:0][3:0][7:0]  cipher_key_i = '0;
  logic [3:0][3:0][7:0]  round_key_o;
  logic                  key_vld_o, key_exp_busy_o, key_exp_done_o, key_sel_err_o;
  int                    checks = 0;
  int                    failures = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  always #5 aes_clk = ~aes_clk;

  aes_key_expander dut (
    .aes_clk(aes_clk), .resetn(resetn), .key_exp_en(key_exp_en), .key_load_i(key_load_i),
    .cipher_key_i(cipher_key_i), .key_req_i(key_req_i), .key_sel_i(key_sel_i),
    .key_vld_o(key_vld_o), .round_key_o(round_key_o), .key_exp_busy_o(key_exp_busy_o),
    .key_exp_done_o(key_exp_done_o), .key_sel_err_o(key_sel_err_o)
  );

  function automatic logic [3:0][3:0][7:0] to_mat(input logic [127:0] v);
    logic [3:0][3:0][7:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = v[127 - 8 * (4 * c + r) -: 8];
    return m;
  endfunction

  function automatic logic [127:0] from_mat(input logic [3:0][3:0][7:0] m);
    logic [127:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) v[127 - 8 * (4 * c + r) -: 8] = m[r][c];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aes_clk);
    #1;
  endtask

  function automatic logic [127:0] flags();
    return {124'd0, key_exp_done_o, key_exp_busy_o, key_vld_o, key_sel_err_o};
  endfunction

  initial begin
    #2;
    chk("reset_flags", flags(), 128'h0);
    chk("reset_key", from_mat(round_key_o), 128'h0);
    tick;
    resetn = 1'b1;
    key_exp_en = 1'b1;
    // load A with a request already held for round 3
    cipher_key_i = to_mat(KEY_A);
    key_load_i = 1'b1;
    key_req_i = 1'b1;
    key_sel_i = 4'd3;
    tick;
    key_load_i = 1'b0;
    chk("load_busy", flags(), 128'b0100);
    for (int i = 1; i < 10; i++) begin
      tick;
      chk($sformatf("expand_%0d", i), flags(), 128'b0100);
    end
    tick;
    chk("done_at_10", flags(), 128'b1000);
    tick;
    chk("held_req_flags", flags(), 128'b1010);
    chk("held_req_key", from_mat(round_key_o), rk[3]);
    // back-to-back requests over every round
    for (int i = 0; i < 11; i++) begin
      key_sel_i = 4'(i);
      tick;
      chk($sformatf("b2b_vld_%0d", i), flags(), 128'b1010);
      chk($sformatf("b2b_key_%0d", i), from_mat(round_key_o), rk[i]);
    end
    key_req_i = 1'b0;
    tick;
    chk("noreq_flags", flags(), 128'b1000);
    chk("noreq_hold", from_mat(round_key_o), rk[10]);
    // out-of-range selects
    key_req_i = 1'b1;
    key_sel_i = 4'd11;
    tick;
    chk("err_sel11", flags(), 128'b1001);
    key_sel_i = 4'd15;
    tick;
    chk("err_sel15", flags(), 128'b1001);
    key_req_i = 1'b0;
    tick;
    chk("err_clear", flags(), 128'b1000);
    // load and request together in READY: load wins
    key_load_i = 1'b1;
    key_req_i = 1'b1;
    key_sel_i = 4'd0;
    tick;
    key_load_i = 1'b0;
    key_req_i = 1'b0;
    chk("load_wins", flags(), 128'b0100);
    repeat (4) tick;
    // restart with zero key at cnt=5
    cipher_key_i = '0;
    key_load_i = 1'b1;
    tick;
    key_load_i = 1'b0;
    chk("reload_busy", flags(), 128'b0100);
    for (int i = 1; i < 10; i++) begin
      tick;
      chk($sformatf("reexpand_%0d", i), flags(), 128'b0100);
    end
    tick;
    chk("redone_at_10", flags(), 128'b1000);
    key_req_i = 1'b1;
    key_sel_i = 4'd10;
    tick;
    chk("zero_r10", from_mat(round_key_o), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    key_sel_i = 4'd1;
    tick;
    chk("zero_r1", from_mat(round_key_o), 128'h62636363626363636263636362636363);
    key_sel_i = 4'd0;
    tick;
    chk("zero_r0", from_mat(round_key_o), 128'h0);
    key_req_i = 1'b0;
    // asynchronous reset at cnt=4
    cipher_key_i = to_mat(KEY_A);
    key_load_i = 1'b1;
    tick;
    key_load_i = 1'b0;
    repeat (3) tick;
    chk("pre_reset_busy", flags(), 128'b0100);
    resetn = 1'b0;
    #1;
    chk("async_rst_flags", flags(), 128'h0);
    chk("async_rst_key", from_mat(round_key_o), 128'h0);
    #1;
    resetn = 1'b1;
    key_req_i = 1'b1;
    key_sel_i = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("post_rst_%0d", i), flags(), 128'h0);
    end
    key_load_i = 1'b1;
    tick;
    key_load_i = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick;
      chk($sformatf("rst_expand_%0d", i), flags(), 128'b0100);
    end
    tick;
    chk("rst_done", flags(), 128'b1000);
    tick;
    chk("rst_serve_flags", flags(), 128'b1010);
    chk("rst_serve_key", from_mat(round_key_o), rk[1]);
    // disable drops to IDLE and stops serving
    key_exp_en = 1'b0;
    key_req_i = 1'b0;
    tick;
    chk("disable", flags(), 128'h0);
    key_exp_en = 1'b1;
    key_req_i = 1'b1;
    key_sel_i = 4'd2;
    tick;
    chk("idle_no_serve", flags(), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
